// File: rtl/fpu_issue_ctrl.sv
// Initiator side of the FPU op/fin interface: latches one issued op, holds it on the
// FPU inputs until fin (or watchdog expiry), then presents the result for writeback.
module fpu_issue_ctrl #(
    parameter logic [3:0]  IDLE_OP    = 4'b1101,
    parameter int unsigned MAX_CYCLES = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    input  logic [4:0]  req_rd,
    output logic [31:0] fpu_src0,
    output logic [31:0] fpu_src1,
    output logic [3:0]  fpu_op,
    input  logic [31:0] fpu_result,
    input  logic        fpu_fin,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_int,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t           state_q;
    logic [3:0]       fpu_op_q;
    logic [31:0]      fpu_src0_q;
    logic [31:0]      fpu_src1_q;
    logic             wb_valid_q;
    logic [31:0]      wb_data_q;
    logic [4:0]       wb_rd_q;
    logic             wb_int_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    assign req_ready = (state_q == IDLE) | ((state_q == WB) & wb_ready);
    assign accept    = req_valid & req_ready;
    assign busy      = (state_q != IDLE);

    assign fpu_op    = fpu_op_q;
    assign fpu_src0  = fpu_src0_q;
    assign fpu_src1  = fpu_src1_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign wb_int    = wb_int_q;
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            fpu_op_q   <= IDLE_OP;
            fpu_src0_q <= '0;
            fpu_src1_q <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_int_q   <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else if (accept) begin
            // Accept happens from IDLE or from WB on the writeback handshake (no bubble).
            state_q    <= EXEC;
            fpu_op_q   <= req_op;
            fpu_src0_q <= req_src0;
            fpu_src1_q <= req_src1;
            wb_rd_q    <= req_rd;
            wb_int_q   <= (req_op[3:2] == 2'b10);
            wb_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                EXEC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (fpu_fin) begin
                        wb_data_q  <= fpu_result;
                        wb_valid_q <= 1'b1;
                        fpu_op_q   <= IDLE_OP;
                        state_q    <= WB;
                    end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                        timeout_q  <= 1'b1;
                        wb_data_q  <= '0;
                        wb_valid_q <= 1'b1;
                        fpu_op_q   <= IDLE_OP;
                        state_q    <= WB;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    fpu_op_q <= IDLE_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed ops against an FPU stub, scoreboard checked by a
// monitor on every writeback presentation.
module tb_fpu_issue_ctrl;

    localparam logic [3:0] IDLE_OP = 4'b1101;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_src0;
    logic [31:0] req_src1;
    logic [4:0]  req_rd;
    logic [31:0] fpu_src0;
    logic [31:0] fpu_src1;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        fpu_fin;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_int;
    logic        busy;
    logic        timeout;

    fpu_issue_ctrl #(.IDLE_OP(IDLE_OP), .MAX_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src0(req_src0), .req_src1(req_src1), .req_rd(req_rd),
        .fpu_src0(fpu_src0), .fpu_src1(fpu_src1), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .fpu_fin(fpu_fin),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_int(wb_int), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // FPU stub: fixed latency per opcode, counted from the first non-idle cycle.
    logic       stub_stuck = 1'b0;
    logic [4:0] stub_cnt;

    function automatic int stub_lat(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010: return 4;
            4'b0011:                   return 11;
            4'b0100:                   return 8;
            4'b1011, 4'b1100:          return 2;
            default:                   return 1;
        endcase
    endfunction

    function automatic logic [31:0] stub_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'b0000 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 4'b0000 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (op == 4'b0010 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 4'b0011 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (op == 4'b1000) return (a == b) ? 32'h1 : 32'h0;
        if (op == 4'b1011 && a == 32'h40400000) return 32'h3;
        if (op == 4'b0100 && a == 32'h40000000) return 32'h3FB504F3;
        return 32'hBAD00000 | {28'h0, op};
    endfunction

    always @(posedge clk) begin
        if (!rstn || fpu_op == IDLE_OP) stub_cnt <= '0;
        else                            stub_cnt <= stub_cnt + 5'd1;
    end

    always_comb begin
        fpu_fin    = 1'b0;
        fpu_result = '0;
        if (!stub_stuck) begin
            if (fpu_op == IDLE_OP) fpu_fin = 1'b1;
            else if (int'(stub_cnt) == stub_lat(fpu_op) - 1) begin
                fpu_fin    = 1'b1;
                fpu_result = stub_res(fpu_op, fpu_src0, fpu_src1);
            end
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wint;
        logic        to;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 0;

    // Monitor: samples 2 time units after negedge, after stimulus has settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rstn && wb_valid) begin
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_wb: got rd %0d data %08h expected no writeback (cyc %0d)", wb_rd, wb_data, cyc);
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1;
                        chk("wb_cycle", cyc, cur.cyc);
                        chk("wb_data", wb_data, cur.data);
                        chk("wb_rd", {27'h0, wb_rd}, {27'h0, cur.rd});
                        chk("wb_int", {31'h0, wb_int}, {31'h0, cur.wint});
                        chk("wb_timeout", {31'h0, timeout}, {31'h0, cur.to});
                    end
                end else begin
                    chk("wb_hold_data", wb_data, cur.data);
                    chk("wb_hold_rd", {27'h0, wb_rd}, {27'h0, cur.rd});
                    chk("wb_hold_int", {31'h0, wb_int}, {31'h0, cur.wint});
                end
                if (wb_ready) have_cur = 0;
            end
        end
    end

    task automatic push(input int c, input logic [31:0] d, input logic [4:0] rd, input logic wi, input logic to);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        e.rd   = rd;
        e.wint = wi;
        e.to   = to;
        sb.push_back(e);
    endtask

    // Issue with wb_ready=1 and check the EXEC/WB/IDLE sequence; lat is the hand-computed EXEC count.
    task automatic run_op(input logic [3:0] op, input logic [31:0] s0, input logic [31:0] s1,
                          input logic [4:0] rd, input int lat, input logic [31:0] exp_d,
                          input logic exp_int, input logic exp_to);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_src0 = s0; req_src1 = s1; req_rd = rd; wb_ready = 1'b1;
        #1;
        chk("req_ready_issue", {31'h0, req_ready}, 32'h1);
        push(cyc + 1 + lat, exp_d, rd, exp_int, exp_to);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk("exec_fpu_op", {28'h0, fpu_op}, {28'h0, op});
            chk("exec_src0", fpu_src0, s0);
            chk("exec_src1", fpu_src1, s1);
            chk("exec_req_ready", {31'h0, req_ready}, 32'h0);
            chk("exec_busy", {31'h0, busy}, 32'h1);
        end
        @(negedge clk);
        #1;
        chk("wb_fpu_op", {28'h0, fpu_op}, {28'h0, IDLE_OP});
        chk("wb_busy", {31'h0, busy}, 32'h1);
        chk("wb_valid_up", {31'h0, wb_valid}, 32'h1);
        @(negedge clk);
        #1;
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("idle_wb_valid", {31'h0, wb_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish within bound");
        $fatal(1, "bench time limit");
    end

    initial begin
        int c1;
        rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_src0 = '0; req_src1 = '0;
        req_rd = '0; wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
        chk("rst_wb_int", {31'h0, wb_int}, 32'h0);
        chk("rst_timeout", {31'h0, timeout}, 32'h0);
        chk("rst_fpu_op", {28'h0, fpu_op}, {28'h0, IDLE_OP});
        chk("rst_src0", fpu_src0, 32'h0);
        chk("rst_src1", fpu_src1, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rstn = 1'b1;

        run_op(4'b0000, 32'h3F800000, 32'h40000000, 5'd5, 4, 32'h40400000, 1'b0, 1'b0);
        run_op(4'b1000, 32'h3F800000, 32'h3F800000, 5'd3, 1, 32'h00000001, 1'b1, 1'b0);
        run_op(4'b1011, 32'h40400000, 32'h00000000, 5'd4, 2, 32'h00000003, 1'b1, 1'b0);
        run_op(4'b0011, 32'h40C00000, 32'h40000000, 5'd6, 11, 32'h40400000, 1'b0, 1'b0);

        // Backpressure: fmul held 5 cycles, then fadd accepted on the handshake cycle.
        @(negedge clk);
        wb_ready = 1'b0; req_valid = 1'b1; req_op = 4'b0010;
        req_src0 = 32'h40000000; req_src1 = 32'h40400000; req_rd = 5'd7;
        #1;
        chk("bp_req_ready", {31'h0, req_ready}, 32'h1);
        push(cyc + 5, 32'h40C00000, 5'd7, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (k >= 5) begin
                chk("bp_wb_valid", {31'h0, wb_valid}, 32'h1);
                chk("bp_fpu_op", {28'h0, fpu_op}, {28'h0, IDLE_OP});
                chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            end
        end
        @(negedge clk);
        wb_ready = 1'b1; req_valid = 1'b1; req_op = 4'b0000;
        req_src0 = 32'h3F800000; req_src1 = 32'h3F800000; req_rd = 5'd9;
        #1;
        chk("b2b_req_ready", {31'h0, req_ready}, 32'h1);
        c1 = cyc;
        push(c1 + 5, 32'h40000000, 5'd9, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("b2b_wb_valid_low", {31'h0, wb_valid}, 32'h0);
        chk("b2b_fpu_op", {28'h0, fpu_op}, 32'h0);
        chk("b2b_busy", {31'h0, busy}, 32'h1);
        repeat (6) @(negedge clk);

        // Watchdog: fin never arrives; writeback with data 0 at cycle 17.
        stub_stuck = 1'b1;
        run_op(4'b0000, 32'h3F800000, 32'h40000000, 5'd2, 16, 32'h0, 1'b0, 1'b1);
        stub_stuck = 1'b0;
        #1;
        chk("timeout_sticky", {31'h0, timeout}, 32'h1);
        run_op(4'b1011, 32'h40400000, 32'h0, 5'd11, 2, 32'h00000003, 1'b1, 1'b1);

        // Reset during fsqrt EXEC cycle 3: op discarded, no writeback.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0100; req_src0 = 32'h40000000; req_src1 = '0; req_rd = 5'd12;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rstmid_fpu_op", {28'h0, fpu_op}, {28'h0, IDLE_OP});
        chk("rstmid_busy", {31'h0, busy}, 32'h0);
        chk("rstmid_timeout", {31'h0, timeout}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (12) @(negedge clk);

        run_op(4'b1000, 32'h3F800000, 32'h40000000, 5'd13, 1, 32'h00000000, 1'b1, 1'b0);

        for (int k = 0; k < 20 && (sb.size() != 0 || have_cur); k++) @(negedge clk);
        chk("sb_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Initiator side of the FPU op/fin interface, sitting between decode/issue and the FPU.
- Accepts one FP operation per valid/ready handshake and latches it.
- Drives the FPU operand/opcode inputs stable until fin.
- Captures the result and presents it on a writeback valid/ready port tagged with destination register and target regfile.
- Supplies pipeline stall (busy) and a sticky watchdog error.

Parameters:
IDLE_OP, 4'b1101, opcode driven to the FPU when no op is executing (FPU returns fin=1, result 0, no internal state advance).
MAX_CYCLES, 16, EXEC cycles without fin before the watchdog fires; must exceed the longest FPU latency (11 EXEC cycles, fdiv).
CNT_W, 5, width of the EXEC cycle counter.

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  issue request valid
req_ready  out  1  controller can accept a request
req_op  in  4  FPU opcode (0000 fadd … 1100 fcvt.s.w)
req_src0  in  32  operand 0
req_src1  in  32  operand 1
req_rd  in  5  destination register index
fpu_src0  out  32  to FPU src0
fpu_src1  out  32  to FPU src1
fpu_op  out  4  to FPU fpuop
fpu_result  in  32  FPU result
fpu_fin  in  1  FPU result valid (combinational from FPU)
wb_valid  out  1  writeback valid
wb_ready  in  1  writeback accepted
wb_data  out  32  captured result
wb_rd  out  5  destination register
wb_int  out  1  1 = integer regfile (ops 1000,1001,1010,1011), 0 = FP regfile
busy  out  1  state != IDLE
timeout  out  1  sticky watchdog error

Behaviour:
- Reset: synchronous on rstn=0, shared with the FPU.
  - state=IDLE, wb_valid=0, wb_data=0, wb_rd=0, wb_int=0, timeout=0, counter=0.
  - fpu_op=IDLE_OP, fpu_src0/1=0.
  - Reset mid-operation discards the op; no writeback is produced.
- States: IDLE, EXEC, WB. All outputs are registered except req_ready and busy.
- req_ready = (state==IDLE) | (state==WB & wb_ready). Accept = req_valid & req_ready.
- IDLE:
  - fpu_op=IDLE_OP.
  - On accept: latch op, src0, src1, rd; set wb_int from the op; clear counter; go to EXEC.
- EXEC:
  - fpu_op/fpu_src0/fpu_src1 are driven from the latched values and held constant every EXEC cycle.
  - Counter increments each cycle.
  - If fpu_fin=1: wb_data <= fpu_result, go to WB.
  - Else if counter==MAX_CYCLES-1: timeout <= 1, wb_data <= 0, go to WB.
  - req_ready=0 throughout EXEC.
- WB:
  - wb_valid=1; fpu_op=IDLE_OP, so the FPU state machine stays at 0.
  - wb_data/wb_rd/wb_int are held stable until wb_ready.
  - On wb_ready & ~accept: go to IDLE.
  - On wb_ready & accept: latch the new request and go directly to EXEC (no bubble).
- Latency: request accepted at cycle 0 → wb_valid at cycle 1+L, where L = EXEC cycles:
  - fadd/fsub/fmul: 4
  - fdiv: 11
  - fsqrt: 8
  - fcvt (1011, 1100): 2
  - all others, including unused opcodes 1101–1111: 1
- Because the FPU state is always 0 when EXEC starts, back-to-back issue is safe.
- timeout clears only on reset. The op that timed out still writes back (data 0).
- Width rules: wb_int is decoded from the latched op only. Counter saturation is never reached because the watchdog exits EXEC first.

Test Plan:
- fadd (0000) 3F800000 + 40000000, rd=5, accept cycle 0, wb_ready=1 → fpu_op=0000 cycles 1–4; wb_valid cycle 5, wb_data=40400000, wb_rd=5, wb_int=0; busy 1 during cycles 1–5.
- feq (1000) 3F800000, 3F800000, rd=3 → wb_valid cycle 2, wb_data=00000001, wb_int=1; fcvt.w.s (1011) of 40400000 → wb_valid cycle 3, wb_data=00000003, wb_int=1.
- fdiv (0011) 40C00000 / 40000000 → fpu_src0/1 stable cycles 1–11, req_ready=0 cycles 1–11, wb_valid cycle 12, wb_data=40400000.
- Backpressure: fmul result held with wb_ready=0 for 5 cycles → wb_valid/data/rd stable, fpu_op=IDLE_OP; then wb_ready=1 with req_valid=1 (fadd) the same cycle → fadd accepted, wb_valid low next cycle, fadd writeback 5 cycles after acceptance.
- Watchdog: FPU stub with fpu_fin tied 0, issue fadd at cycle 0 → timeout=1 and wb_valid at cycle 17 with wb_data=0; timeout stays 1 across further ops until rstn=0.
- Reset: fsqrt issued, rstn=0 during EXEC cycle 3 → next cycle state IDLE, wb_valid=0, fpu_op=IDLE_OP, req_ready=1 after rstn releases; no writeback ever appears for the fsqrt.
